// File: rtl/summation_scheduler.sv
// ---------------------------------------------------------------------------
// summation_scheduler
//
// Purpose:
//   Shares one summation engine (sum of i for i = 1..N) among NUM_REQ
//   requesters. A round-robin arbiter accepts one request at a time. The
//   scheduler issues a single-cycle start to the engine and waits for its
//   done pulse, giving up after TIMEOUT cycles. It then returns the result,
//   tagged with the requester id, through a held valid/ready response.
//   A request with N == 0 bypasses the engine and answers 0 directly.
//
// Parameters:
//   NUM_REQ  number of requesters (power of two, >= 2)
//   N_W      width of N
//   SUM_W    width of the sum (>= 2*N_W-1)
//   TIMEOUT  maximum number of WAIT cycles before a request is aborted
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_n      in   [NUM_REQ*N_W]    per-requester N, requester k at [k*N_W +: N_W]
//   req_ready  out  [NUM_REQ]        one-hot grant, combinational, only in IDLE
//   eng_start  out                   one-cycle start pulse to the engine
//   eng_n      out  [N_W]            N presented to the engine
//   eng_done   in                    engine completion pulse
//   eng_sum    in   [SUM_W]          engine result, valid with eng_done
//   rsp_valid  out                   response valid
//   rsp_id     out  [log2(NUM_REQ)]  owner of the response
//   rsp_sum    out  [SUM_W]          result
//   rsp_err    out                   request timed out
//   rsp_ready  in                    response accept
//   busy       out                   high in every state except IDLE
// ---------------------------------------------------------------------------
module summation_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int N_W     = 4,
    parameter int SUM_W   = 7,
    parameter int TIMEOUT = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N_W-1:0]     req_n,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_start,
    output logic [N_W-1:0]             eng_n,
    input  logic                       eng_done,
    input  logic [SUM_W-1:0]           eng_sum,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [SUM_W-1:0]           rsp_sum,
    output logic                       rsp_err,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    // One spare bit so TIMEOUT-1 is always representable.
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [TMR_W-1:0] r_timer;
    logic [ID_W-1:0]  r_id;
    logic [N_W-1:0]   r_n;
    logic [SUM_W-1:0] r_sum;
    logic             r_err;

    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_scan_idx;
    logic [N_W-1:0]   w_sel_n;
    logic             w_accept;
    logic             w_timeout;

    // Round-robin search: walk the requesters starting at r_ptr. NUM_REQ is
    // a power of two, so the ID_W-bit add wraps modulo NUM_REQ by itself.
    // The first valid requester found wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = r_ptr + ID_W'(i);
            if (!w_grant_vld && req_valid[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_scan_idx;
            end
        end
    end

    // Grants exist only in IDLE. They are forced off while reset is held,
    // so nothing can handshake in a cycle that the reset edge will discard.
    always_comb begin
        req_ready = '0;
        if (reset_n && (r_state == S_IDLE) && w_grant_vld) begin
            req_ready = NUM_REQ'(1) << w_grant_id;
        end
    end

    assign w_accept  = reset_n && (r_state == S_IDLE) && w_grant_vld;
    assign w_sel_n   = req_n[w_grant_id*N_W +: N_W];
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    // Main control. The request (id, N) is latched only at the handshake,
    // so later changes to req_n do not matter. In WAIT, a done pulse is
    // checked before the timeout, so done wins when both happen in the
    // same cycle. eng_done is looked at in no other state. That is how
    // late or stray pulses get dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_timer <= '0;
            r_id    <= '0;
            r_n     <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_grant_id;
                        r_n   <= w_sel_n;
                        r_ptr <= w_grant_id + 1'b1;
                        if (w_sel_n == '0) begin
                            r_sum   <= '0;
                            r_err   <= 1'b0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_sum   <= eng_sum;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_sum   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The response fields come straight from the registers. They cannot
    // change while in RESP, so they stay stable under backpressure.
    assign eng_start = (r_state == S_ISSUE);
    assign eng_n     = r_n;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_err   = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_summation_scheduler.sv
// ---------------------------------------------------------------------------
// tb_summation_scheduler
//
// Purpose:
//   Self-checking bench for summation_scheduler. It uses directed
//   scenarios followed by randomized requests. The expected grant order,
//   response timing and response contents come from a request-level
//   model: a round-robin pointer plus arithmetic on the engine delay.
//   An engine model inside the bench supplies done pulses.
// ---------------------------------------------------------------------------
module tb_summation_scheduler;

    localparam int NUM_REQ = 4;
    localparam int N_W     = 4;
    localparam int SUM_W   = 7;
    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1000;

    logic                       clock;
    logic                       reset_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*N_W-1:0]     req_n;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       eng_start;
    logic [N_W-1:0]             eng_n;
    logic                       eng_done;
    logic [SUM_W-1:0]           eng_sum;
    logic                       rsp_valid;
    logic [$clog2(NUM_REQ)-1:0] rsp_id;
    logic [SUM_W-1:0]           rsp_sum;
    logic                       rsp_err;
    logic                       rsp_ready;
    logic                       busy;

    int checks   = 0;
    int failures = 0;
    int modelPtr = 0;

    summation_scheduler #(
        .NUM_REQ(NUM_REQ),
        .N_W    (N_W),
        .SUM_W  (SUM_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_n    (req_n),
        .req_ready(req_ready),
        .eng_start(eng_start),
        .eng_n    (eng_n),
        .eng_done (eng_done),
        .eng_sum  (eng_sum),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_err  (rsp_err),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so a stuck run still ends with a report.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one complete request. The task starts at the beginning of an
    // IDLE cycle and returns at the beginning of the next IDLE cycle.
    // engDelay is the number of cycles after eng_start before the engine
    // pulses done. rspHold is the number of RESP cycles with rsp_ready low.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valids,
                                 input logic [NUM_REQ*N_W-1:0] ns,
                                 input int engDelay, input int rspHold);
        int k;
        int n;
        int trueSum;
        int expSum;
        int respCycle;
        logic expErr;
        logic honoured;

        k = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (k < 0 && valids[(modelPtr + i) % NUM_REQ]) k = (modelPtr + i) % NUM_REQ;
        end
        if (k < 0) begin
            checkOutput("grantExists", 32'd0, 32'd1);
            return;
        end
        n = int'(ns[k*N_W +: N_W]);
        trueSum = n * (n + 1) / 2;
        if (n == 0) begin
            expSum = 0; expErr = 1'b0; respCycle = 1;
        end else if (engDelay <= TIMEOUT) begin
            expSum = trueSum; expErr = 1'b0; respCycle = 2 + engDelay;
        end else begin
            expSum = 0; expErr = 1'b1; respCycle = 2 + TIMEOUT;
        end

        // Handshake cycle
        req_valid = valids;
        req_n     = ns;
        @(negedge clock);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("grant", 32'(req_ready), 32'd1 << k);
        modelPtr = (k + 1) % NUM_REQ;

        for (int c = 1; c <= respCycle + rspHold; c++) begin
            @(posedge clock);
            #1;
            req_n     = NUM_REQ*N_W'($urandom);
            honoured  = (n != 0) && (c == 1 + engDelay) && (c < respCycle);
            eng_done  = honoured || (c == respCycle);
            eng_sum   = honoured ? SUM_W'(trueSum) : SUM_W'($urandom);
            rsp_ready = (c == respCycle + rspHold);
            @(negedge clock);
            checkOutput("busyHigh", 32'(busy), 32'd1);
            checkOutput("readyLow", 32'(req_ready), 32'd0);
            checkOutput("engStart", 32'(eng_start), 32'((c == 1) && (n != 0)));
            if (c == 1 && n != 0) checkOutput("engN", 32'(eng_n), 32'(n));
            if (c < respCycle) begin
                checkOutput("noRspYet", 32'(rsp_valid), 32'd0);
            end else begin
                checkOutput("rspValid", 32'(rsp_valid), 32'd1);
                checkOutput("rspId", 32'(rsp_id), 32'(k));
                checkOutput("rspSum", 32'(rsp_sum), 32'(expSum));
                checkOutput("rspErr", 32'(rsp_err), 32'(expErr));
            end
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        eng_done  = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0]     rv;
        logic [NUM_REQ*N_W-1:0] rn;
        int sel;
        int dly;

        reset_n   = 1'b0;
        req_valid = '1;
        req_n     = '0;
        eng_done  = 1'b0;
        eng_sum   = '0;
        rsp_ready = 1'b0;

        // Reset: outputs at their reset values, and grants are forced off
        // even though every requester is valid.
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rstReady", 32'(req_ready), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstStart", 32'(eng_start), 32'd0);
        checkOutput("rstEngN", 32'(eng_n), 32'd0);
        checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstRspId", 32'(rsp_id), 32'd0);
        checkOutput("rstRspSum", 32'(rsp_sum), 32'd0);
        checkOutput("rstRspErr", 32'(rsp_err), 32'd0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        req_valid = '0;

        $display("[TB] round-robin fairness");
        for (int j = 0; j < 5; j++) applyStimulus(4'hF, {4'd15, 4'd3, 4'd2, 4'd1}, 2, 0);

        $display("[TB] single request");
        applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd4}, 5, 0);

        $display("[TB] N=0 bypass");
        applyStimulus(4'b0100, {4'd7, 4'd0, 4'd5, 4'd5}, 3, 0);

        $display("[TB] timeout with late done");
        applyStimulus(4'b0010, {4'd0, 4'd0, 4'd7, 4'd0}, NEVER, 0);

        $display("[TB] timeout boundaries");
        applyStimulus(4'b1000, {4'd9, 4'd0, 4'd0, 4'd0}, TIMEOUT, 0);
        applyStimulus(4'b1000, {4'd9, 4'd0, 4'd0, 4'd0}, TIMEOUT + 1, 0);

        $display("[TB] response backpressure");
        applyStimulus(4'b1001, {4'd6, 4'd0, 4'd0, 4'd11}, 4, 10);
        applyStimulus(4'b1001, {4'd6, 4'd0, 4'd0, 4'd11}, 1, 0);

        $display("[TB] reset during WAIT");
        req_valid = 4'b0100;
        req_n     = {4'd0, 4'd9, 4'd0, 4'd0};
        @(negedge clock);
        checkOutput("midGrant", 32'(req_ready), 32'b0100);
        @(posedge clock);
        #1;
        req_valid = '0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("midWaitBusy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        eng_done = 1'b1;
        eng_sum  = SUM_W'(45);
        @(negedge clock);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstStart", 32'(eng_start), 32'd0);
        checkOutput("midRstEngN", 32'(eng_n), 32'd0);
        checkOutput("midRstRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("midRstRspId", 32'(rsp_id), 32'd0);
        checkOutput("midRstRspSum", 32'(rsp_sum), 32'd0);
        checkOutput("midRstRspErr", 32'(rsp_err), 32'd0);
        @(posedge clock);
        #1;
        eng_done = 1'b0;
        @(negedge clock);
        checkOutput("abortNoRsp", 32'(rsp_valid), 32'd0);
        checkOutput("abortIdle", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        modelPtr = 0;
        applyStimulus(4'hF, {4'd1, 4'd2, 4'd3, 4'd5}, 3, 0);

        $display("[TB] randomized requests");
        for (int j = 0; j < 30; j++) begin
            rv  = NUM_REQ'($urandom_range(1, 15));
            rn  = NUM_REQ*N_W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      dly = TIMEOUT + 5;
            else if (sel == 1) dly = TIMEOUT;
            else               dly = $urandom_range(1, 6);
            applyStimulus(rv, rn, dly, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
